// File: rtl/sha2_message_pad_pkg.sv
// Shared types and constants for the SHA-2 message builder.
package sha2_msg_pkg;

  localparam int unsigned SHA256_BLOCK_W = 512;
  localparam int unsigned SHA512_BLOCK_W = 1024;

  typedef enum logic [1:0] {
    SCHEME_PAD  = 2'b00,
    SCHEME_PASS = 2'b01
  } scheme_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DATA = ST_DATA,
    S_PAD  = ST_PAD
  } state_e;

  function automatic int unsigned len_w(input int unsigned block_w);
    return block_w / 8;
  endfunction

endpackage

// File: rtl/sha2_message_pad_if.sv
// Host-side and core-side handshakes of the SHA-2 message builder.
interface sha2_message_pad_if #(
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned SIZE_W  = 64
);
  logic [BLOCK_W-1:0] data_in;
  logic               data_in_valid;
  logic               data_in_ready;
  logic               data_in_last;
  logic [SIZE_W-1:0]  cfg_size;
  logic [1:0]         cfg_scheme;
  logic               cfg_last;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [BLOCK_W-1:0] data_out;
  logic               data_out_valid;
  logic               data_out_ready;
  logic               data_out_last;
  logic               done;
  logic               err;

  modport master (
    output data_in, data_in_valid, data_in_last,
    output cfg_size, cfg_scheme, cfg_last, cfg_valid,
    output data_out_ready,
    input  data_in_ready, cfg_ready, data_out, data_out_valid, data_out_last, done, err
  );

  modport slave (
    input  data_in, data_in_valid, data_in_last,
    input  cfg_size, cfg_scheme, cfg_last, cfg_valid,
    input  data_out_ready,
    output data_in_ready, cfg_ready, data_out, data_out_valid, data_out_last, done, err
  );
endinterface

// File: rtl/sha2_message_pad_block.sv
// Combinational padding of the final message beat and the trailing length block.
module sha2_pad_block #(
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned SIZE_W  = 64,
  parameter int unsigned LEN_W   = 64,
  parameter int unsigned LOG_BW  = $clog2(BLOCK_W)
) (
  input  logic [BLOCK_W-1:0] i_beat,
  input  logic [LOG_BW-1:0]  i_r,
  input  logic [SIZE_W-1:0]  i_size,
  input  logic               i_full,
  output logic [BLOCK_W-1:0] o_block,
  output logic               o_overflow,
  output logic [BLOCK_W-1:0] o_len_block
);
  localparam logic [BLOCK_W-1:0] TOP_ONE = {1'b1, {(BLOCK_W-1){1'b0}}};

  logic [BLOCK_W-1:0] w_keep;
  logic [BLOCK_W-1:0] w_one;
  logic [BLOCK_W-1:0] w_len;

  assign w_keep     = i_full ? '1 : ~({BLOCK_W{1'b1}} >> i_r);
  assign w_one      = i_full ? '0 : (TOP_ONE >> i_r);
  assign w_len      = BLOCK_W'(LEN_W'(i_size));
  // The length field fits only when the 1-bit lands above the low LEN_W bits.
  assign o_overflow = i_full | (i_r > LOG_BW'(BLOCK_W - LEN_W - 1));

  assign o_block     = (i_beat & w_keep) | w_one | (o_overflow ? '0 : w_len);
  assign o_len_block = (i_full ? TOP_ONE : '0) | w_len;

endmodule

// File: rtl/sha2_message_pad.sv
// SHA-2 message builder: pads arbitrary-length messages into BLOCK_W-bit blocks.
// Optional framing check enabled by defining MESSAGE_BUILD_ERR_CHECK_EN.
module sha2_message_pad
  import sha2_msg_pkg::*;
#(
  parameter int unsigned BLOCK_W = SHA256_BLOCK_W,
  parameter int unsigned SIZE_W  = 64,
  parameter int unsigned LEN_W   = len_w(BLOCK_W)
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic sync_rst,
  sha2_message_pad_if.slave bus
);
  localparam int unsigned LOG_BW = $clog2(BLOCK_W);
  localparam int unsigned CNT_W  = SIZE_W - LOG_BW + 1;

  state_e             r_state;
  logic [SIZE_W-1:0]  r_size;
  logic               r_pass;
  logic               r_job_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [BLOCK_W-1:0] r_out;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_out_job_last;

  logic               w_out_free;
  logic               w_cfg_fire;
  logic               w_in_fire;
  logic               w_pad_fire;
  logic               w_out_fire;
  logic               w_final_beat;
  logic [LOG_BW-1:0]  w_r;
  logic               w_full;
  logic [CNT_W-1:0]   w_cnt_ceil;
  logic [CNT_W-1:0]   w_cnt_init;
  logic [BLOCK_W-1:0] w_padded;
  logic               w_overflow;
  logic [BLOCK_W-1:0] w_len_blk;

  assign w_out_free   = !r_out_valid || bus.data_out_ready;
  assign w_cfg_fire   = bus.cfg_valid && bus.cfg_ready;
  assign w_in_fire    = bus.data_in_valid && bus.data_in_ready;
  assign w_pad_fire   = en && (r_state == S_PAD) && w_out_free;
  assign w_out_fire   = en && r_out_valid && bus.data_out_ready;
  assign w_final_beat = (r_cnt == CNT_W'(1));
  assign w_r          = r_size[LOG_BW-1:0];
  assign w_full       = (r_size != '0) && (w_r == '0);

  assign w_cnt_ceil = CNT_W'(bus.cfg_size >> LOG_BW) + CNT_W'(|bus.cfg_size[LOG_BW-1:0]);
  assign w_cnt_init = (w_cnt_ceil == '0) ? CNT_W'(1) : w_cnt_ceil;

  assign bus.cfg_ready      = en && (r_state == S_IDLE);
  assign bus.data_in_ready  = en && (r_state == S_DATA) && w_out_free;
  assign bus.data_out       = r_out;
  assign bus.data_out_valid = r_out_valid;
  assign bus.data_out_last  = r_out_last;
  assign bus.done           = !sync_rst && w_out_fire && r_out_last && r_out_job_last;

  sha2_pad_block #(
    .BLOCK_W (BLOCK_W),
    .SIZE_W  (SIZE_W),
    .LEN_W   (LEN_W),
    .LOG_BW  (LOG_BW)
  ) u_pad (
    .i_beat      (bus.data_in),
    .i_r         (w_r),
    .i_size      (r_size),
    .i_full      (w_full),
    .o_block     (w_padded),
    .o_overflow  (w_overflow),
    .o_len_block (w_len_blk)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= S_IDLE;
      r_size         <= '0;
      r_pass         <= 1'b0;
      r_job_last     <= 1'b0;
      r_cnt          <= '0;
      r_out          <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_job_last <= 1'b0;
    end else if (sync_rst) begin
      r_state        <= S_IDLE;
      r_size         <= '0;
      r_pass         <= 1'b0;
      r_job_last     <= 1'b0;
      r_cnt          <= '0;
      r_out          <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_job_last <= 1'b0;
    end else if (en) begin
      // A block leaving the register frees it; a load below in the same cycle wins.
      if (w_out_fire) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cfg_fire) begin
            r_size     <= bus.cfg_size;
            r_pass     <= (bus.cfg_scheme == SCHEME_PASS);
            r_job_last <= bus.cfg_last;
            r_cnt      <= w_cnt_init;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_in_fire) begin
            r_out_valid    <= 1'b1;
            r_out_job_last <= r_job_last;
            if (r_pass) begin
              r_out      <= bus.data_in;
              r_out_last <= bus.data_in_last;
              if (bus.data_in_last) r_state <= S_IDLE;
            end else if (!w_final_beat) begin
              r_out      <= bus.data_in;
              r_out_last <= 1'b0;
              r_cnt      <= r_cnt - CNT_W'(1);
            end else if (w_overflow) begin
              r_out      <= w_padded;
              r_out_last <= 1'b0;
              r_state    <= S_PAD;
            end else begin
              r_out      <= w_padded;
              r_out_last <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_PAD: begin
          if (w_pad_fire) begin
            r_out          <= w_len_blk;
            r_out_last     <= 1'b1;
            r_out_valid    <= 1'b1;
            r_out_job_last <= r_job_last;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MESSAGE_BUILD_ERR_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_err <= 1'b0;
    end else if (sync_rst) begin
      r_err <= 1'b0;
    end else if (en) begin
      if ((r_state == S_DATA) && w_in_fire && !r_pass && (bus.data_in_last != w_final_beat))
        r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: doc/sha2_message_pad.md
# sha2_message_pad

Parametrised SHA-2 message builder. It sits between the host data stream and the SHA-2 compression core, and converts a message of arbitrary bit length into a sequence of `BLOCK_W`-bit padded message blocks. It generalises the fixed 512-bit message builder:
- selectable block size: 512 for SHA-224/256, 1024 for SHA-384/512;
- a pass-through scheme;
- an end-of-job indication;
- optional framing checks.

## Interface
Parameters:
- `BLOCK_W`, 512, block width in bits; legal values 512 or 1024.
- `SIZE_W`, 64, width of `cfg_size` (message length in bits).
- `LEN_W`, `BLOCK_W/8`, width of the length field appended to the message (64 or 128). `cfg_size` is zero-extended to this width.

Ports (clock and reset first). The block has one clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `nrst` in 1: asynchronous active-low reset.
- `en` in 1: enable. When 0, all readies are 0 and all state is frozen.
- `sync_rst` in 1: synchronous reset. Has priority over `en`.
- `data_in` in `BLOCK_W`: message bits. Bit `BLOCK_W-1` is the first message bit.
- `data_in_valid` in 1, `data_in_ready` out 1, `data_in_last` in 1: input data handshake; `data_in_last` marks the final input beat of the message.
- `cfg_size` in `SIZE_W`: message length in bits.
- `cfg_scheme` in 2: 00 = pad, 01 = pass-through, 1x = treated as pad.
- `cfg_last` in 1: this is the final message of the job.
- `cfg_valid` in 1, `cfg_ready` out 1: configuration handshake.
- `data_out` out `BLOCK_W`, `data_out_valid` out 1, `data_out_ready` in 1, `data_out_last` out 1: output block handshake; `data_out_last` marks the final block of the message.
- `done` out 1: one-cycle pulse on the handshake of the final block of a message whose `cfg_last` was 1.
- `err` out 1: sticky framing error flag.

## Operation
- State machine states: IDLE, DATA, PAD.
- **IDLE**
  - `cfg_ready` = `en`.
  - On `cfg_valid & cfg_ready`: capture size, scheme and last.
  - Load the beat counter with `max(1, ceil(size/BLOCK_W))`.
  - Go to DATA.
- **DATA**
  - `data_in_ready` = `en & (!data_out_valid | data_out_ready)`.
  - Non-final beat: forward unchanged, with `data_out_last`=0.
  - Final beat (counter = 1), pad scheme:
    - Let `r = size mod BLOCK_W`; when `size > 0` and `r = 0`, the final beat is full.
    - If not full and `r <= BLOCK_W-LEN_W-1`: keep the top `r` bits, set the next bit to 1, zero the rest, place the length in the low `LEN_W` bits. Emit with `last`=1 and go to IDLE.
    - Otherwise: emit the kept bits plus the 1-bit (no 1-bit if the beat is full) with zero fill and `last`=0, then go to PAD.
    - `size = 0`: the data beat is consumed and ignored; emit `0x80…00` with a zero length field and `last`=1.
  - Pass-through scheme: every beat is forwarded unchanged; `data_out_last` = `data_in_last`.
- **PAD**
  - When the output register is free, load the length block: a leading 1 only if the final data beat was full, zeros, then the length in the low bits, with `last`=1.
  - Go to IDLE.
- Arithmetic: the beat counter is `SIZE_W-log2(BLOCK_W)+1` bits wide. `r` uses the low `log2(BLOCK_W)` bits of size.

## Timing
- Reset values: `data_out`=0, `data_out_valid`=0, `data_out_last`=0, `done`=0, `err`=0, state = IDLE.
- `cfg_ready` is combinational from state; it equals `en` in IDLE, including while `nrst` is low.
- Latency:
  - Data beat handshake to `data_out_valid`: 1 cycle.
  - PAD block: the cycle after the previous block leaves the register.
  - Return to IDLE to the next `cfg_ready`: 0 cycles; a new cfg may be accepted in the cycle after the final block is loaded.
- The output register holds `data_out` and `data_out_last` stable while `valid & !ready`. It never drops `valid` without a handshake, except under a reset.
- `sync_rst` or `nrst` mid-message: discard everything, return to the reset values immediately, and clear `err`.
- `en`=0 mid-message: freeze all state. `data_out_valid` stays asserted but no state advances. `data_out_ready` is ignored for handshake purposes while `en`=0.

## Configuration
- `MESSAGE_BUILD_ERR_CHECK_EN` defined:
  - `err` is set when `data_in_last` disagrees with the counter on a pad-scheme beat.
  - The counter always governs padding.
- Not defined: `err` is tied to 0 and `data_in_last` is ignored for the pad scheme.

## Structure
- `sha2_msg_pkg` holds:
  - the scheme enum (`SCHEME_PAD`, `SCHEME_PASS`);
  - the state enum;
  - constants `SHA256_BLOCK_W`=512 and `SHA512_BLOCK_W`=1024;
  - function `len_w(block_w)`.
- Sub-module `sha2_pad_block`: combinational. It takes the final beat, `r`, size and a full flag, and produces the padded block, the overflow flag and the length block.

## Test plan
- `BLOCK_W`=512, size 24, `data_in`=`0x616263` in the top bits → one block `0x61626380 0…0 0x18`, `last`=1; with `cfg_last`=1, `done` pulses once.
- Size 440 → single block with the 1-bit at bit position 71. Size 448 → two blocks: `data|1|0…` with `last`=0, then `0…0 0x1C0` with `last`=1.
- Size 512, one full beat → beat unchanged with `last`=0, then `0x80…00 …0x200` with `last`=1. Size 0 → one beat consumed, output `0x80…00`, `last`=1.
- `data_out_ready` low for 5 cycles mid-message → `data_out` stable and `data_in_ready`=0 throughout; no beat lost or duplicated. Assert `sync_rst` mid-PAD → `data_out_valid`=0 next cycle and `cfg_ready`=1.
- `BLOCK_W`=1024, size 24 → `0x61626380…`, 128-bit length `0x18`, one block. With the macro defined, pad scheme, 2-beat size and `data_in_last`=1 on beat 1 → `err`=1 and two padded outputs still produced.
